icache_dm: RTL
==============

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter SETS, default 16, number of lines (power of 2, >=2).
REQ-002 The block SHALL have parameter WORDS, default 2, words per line (power of 2, >=1).
REQ-003 The block SHALL have parameter WORD_W, default 32, data width in bits.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 The block SHALL have port nrst  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port cpu_req  input  1  fetch request, held with cpu_addr stable until cpu_ready.
REQ-007 The block SHALL have port cpu_addr  input  32  byte address of the fetch; bits[1:0] ignored.
REQ-008 The block SHALL have port cpu_ready  output  1  cpu_rdata is valid this cycle.
REQ-009 The block SHALL have port cpu_rdata  output  WORD_W  fetched word.
REQ-010 The block SHALL have port flush  input  1  single-cycle pulse that invalidates all lines.
REQ-011 The block SHALL have port mem_req  output  1  refill read request to backing memory.
REQ-012 The block SHALL have port mem_addr  output  32  word-aligned refill address.
REQ-013 The block SHALL have port mem_rdata  input  WORD_W  refill data, valid with mem_ack.
REQ-014 The block SHALL have port mem_ack  input  1  memory has returned mem_rdata for mem_addr.

Function
REQ-015 Address split SHALL be: offset = bits[2 +: log2(WORDS)], index = next log2(SETS) bits, tag = all remaining upper bits.
REQ-016 Storage SHALL hold, per line: valid bit, tag, and WORDS data words (direct-mapped).
REQ-017 FSM states SHALL be IDLE and FILL only.
REQ-018 In IDLE, hit (cpu_req, line valid, tag match, flush low) SHALL assert cpu_ready and drive cpu_rdata combinationally in the same cycle.
REQ-019 cpu_rdata SHALL be 0 whenever cpu_ready is 0.
REQ-020 In IDLE, a miss SHALL latch tag and index, clear word counter, and enter FILL at the next edge; cpu_ready stays 0.
REQ-021 In FILL, mem_req SHALL be 1 and mem_addr = {latched tag, index, counter, 2'b00}; mem_req SHALL stay 1 until mem_ack.
REQ-022 On each mem_ack in FILL, mem_rdata SHALL be written to word[counter] of the line and the counter incremented.
REQ-023 On the ack for word WORDS-1, tag SHALL be written, valid set (subject to REQ-026), and state returns to IDLE; the held request then hits one cycle later.
REQ-024 Miss latency with zero-wait memory SHALL be WORDS+1 cycles from miss detection to cpu_ready.
REQ-025 flush in IDLE SHALL clear all valid bits at the next edge; flush has priority over a same-cycle cpu_req (cpu_ready 0 that cycle).
REQ-026 flush during FILL SHALL set a pending flag; the fill completes normally on the memory side, then all valid bits are cleared (including the just-filled line) on return to IDLE.
REQ-027 mem_ack outside FILL SHALL be ignored.
REQ-028 A refill to an index SHALL overwrite the previous line there (no replacement choice).

Reset
REQ-029 With nrst low at a rising edge: state IDLE, all valid bits 0, counter 0, flush-pending 0; mem_req, cpu_ready, cpu_rdata read 0 after that edge.
REQ-030 Reset mid-FILL SHALL abandon the refill immediately; the partially filled line stays invalid.
REQ-031 Tag and data arrays SHALL NOT be reset.

Structure
REQ-032 The word and address typedefs SHALL come from the shared types.sv package; the FSM state enum SHALL be added there.
REQ-033 Data storage SHALL be a sub-module icache_line_ram: SETS x WORDS words, one synchronous write port, one combinational read port.

Verification (SETS=16, WORDS=2, memory returns 0xDEAD0000|addr)
REQ-034 After reset, req 0x40 -> cycle0 miss; mem_addr 0x40 then 0x44 with immediate acks; cycle3 cpu_ready=1, cpu_rdata=0xDEAD0040.
REQ-035 Then req 0x44 -> same-cycle cpu_ready=1, cpu_rdata=0xDEAD0044, mem_req stays 0.
REQ-036 Req 0xC0 (index 8, tag 1) -> refill evicts 0x40 line; re-request 0x40 -> misses again with mem_addr 0x40.
REQ-037 flush pulse in IDLE, then req 0x44 -> miss, refill from 0x40.
REQ-038 flush during FILL with mem_ack delayed 3 cycles per word -> both words fetched, return to IDLE, same request misses again.
REQ-039 nrst low during FILL -> next cycle mem_req=0, cpu_ready=0; request for the same line misses.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache: address/word
// types, the controller state enum and a width helper.
package icache_dm_pkg;

    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [31:0]       word_t;

    // Controller has only two states: serving lookups, or refilling a line.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Index width that stays at least 1 bit so single-entry dimensions
    // still produce legal vector declarations.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side bus of the instruction cache.
// slave  = cache side, master = CPU/memory side.
interface icache_dm_if #(
    parameter int WORD_W = 32
);
    import icache_dm_pkg::*;

    logic              cpu_req;
    addr_t             cpu_addr;
    logic              cpu_ready;
    logic [WORD_W-1:0] cpu_rdata;
    logic              flush;

    logic              mem_req;
    addr_t             mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_rdata, mem_ack,
        output cpu_ready, cpu_rdata, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_rdata, mem_ack,
        input  cpu_ready, cpu_rdata, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_line_ram.sv
// Line data storage: SETS x WORDS words, one synchronous write port used by
// the refill engine and one combinational read port used by the lookup.
module icache_line_ram
    import icache_dm_pkg::*;
#(
    parameter  int SETS   = 16,
    parameter  int WORDS  = 2,
    parameter  int WORD_W = 32,
    localparam int IW     = bits_for(SETS),
    localparam int OW     = bits_for(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     widx,
    input  logic [OW-1:0]     woff,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IW-1:0]     ridx,
    input  logic [OW-1:0]     roff,
    output logic [WORD_W-1:0] rdata
);

    // Contents are deliberately not reset; the valid bits gate their use.
    logic [WORD_W-1:0] mem [SETS][WORDS];

    // Refill write, one word per acknowledged memory beat.
    always_ff @(posedge clk) begin
        if (we) mem[widx][woff] <= wdata;
    end

    assign rdata = mem[ridx][roff];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache. Hits return data combinationally in
// the request cycle; misses refill the whole line word by word from
// backing memory, then the held request hits.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int WORDS  = 2,
    parameter int WORD_W = 32
) (
    input  logic       clk,
    input  logic       nrst,
    icache_dm_if.slave bus
);

    // OFF_BITS is the true offset width (0 for one-word lines); OW is the
    // storage width of the word counter, kept >= 1 bit.
    localparam int OFF_BITS = $clog2(WORDS);
    localparam int OW       = bits_for(WORDS);
    localparam int IW       = $clog2(SETS);
    localparam int TAG_LSB  = 2 + OFF_BITS + IW;
    localparam int TAG_W    = ADDR_W - TAG_LSB;
    localparam logic [OW-1:0] LAST_WORD = OW'(WORDS - 1);

    state_t            state_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [TAG_W-1:0]  fill_tag_q;
    logic [IW-1:0]     fill_idx_q;
    logic [OW-1:0]     cnt_q;
    logic              flush_pend_q;
    logic              mem_req_q;

    logic [OW-1:0]     req_off;
    logic [IW-1:0]     req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              miss_start;
    logic              fill_beat;
    logic              last_beat;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_lsbs;

    // Split the fetch address into offset / index / tag.
    always_comb begin
        req_off = '0;
        if (WORDS > 1) req_off = bus.cpu_addr[2 +: OW];
        req_idx = bus.cpu_addr[2 + OFF_BITS +: IW];
        req_tag = bus.cpu_addr[TAG_LSB +: TAG_W];
    end

    assign unused_addr_lsbs = ^bus.cpu_addr[1:0];

    // Lookup and refill handshake qualifiers; flush blocks a same-cycle hit.
    always_comb begin
        hit        = (state_q == IDLE) && bus.cpu_req && !bus.flush &&
                     valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
        miss_start = (state_q == IDLE) && bus.cpu_req && !bus.flush && !hit;
        fill_beat  = (state_q == FILL) && bus.mem_ack;
        last_beat  = fill_beat && (cnt_q == LAST_WORD);
    end

    // Controller: lookup/refill sequencing, valid bits and flush handling.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (miss_start) begin
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    // A flush here must not cut the memory burst short; it
                    // is remembered and applied when the line completes.
                    if (bus.flush) flush_pend_q <= 1'b1;
                    if (fill_beat) cnt_q <= cnt_q + 1'b1;
                    if (last_beat) begin
                        state_q      <= IDLE;
                        mem_req_q    <= 1'b0;
                        cnt_q        <= '0;
                        flush_pend_q <= 1'b0;
                        if (flush_pend_q || bus.flush) valid_q <= '0;
                        else                           valid_q[fill_idx_q] <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Refill target latch and tag write; these carry no reset because the
    // valid bits decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
        end
        if (last_beat) tag_mem[fill_idx_q] <= fill_tag_q;
    end

    icache_line_ram #(
        .SETS   (SETS),
        .WORDS  (WORDS),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (fill_beat),
        .widx  (fill_idx_q),
        .woff  (cnt_q),
        .wdata (bus.mem_rdata),
        .ridx  (req_idx),
        .roff  (req_off),
        .rdata (ram_rdata)
    );

    assign bus.cpu_ready = hit;
    assign bus.cpu_rdata = hit ? ram_rdata : '0;
    assign bus.mem_req   = mem_req_q;

    // Refill address walks the line in word order from word 0.
    generate
        if (WORDS > 1) begin : g_addr_multi
            assign bus.mem_addr = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
        end else begin : g_addr_single
            assign bus.mem_addr = {fill_tag_q, fill_idx_q, 2'b00};
        end
    endgenerate

endmodule
